// File: rtl/alu_seq_msp430_if.sv
// Operand/result handshake bundle between operand fetch, the ALU and write-back.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface alu_seq_msp430_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic             bw;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             out_we;

  modport master (
    output in_valid, op, bw, a, b, out_ready,
    input  in_ready, out_valid, result, result_hi, out_we
  );

  modport slave (
    input  in_valid, op, bw, a, b, out_ready,
    output in_ready, out_valid, result, result_hi, out_we
  );
endinterface

// File: rtl/alu_seq_msp430.sv
// Registered MSP430-style ALU with byte mode, N/Z/C/V status register, BCD add and shift-add multiply.
// Latency: 1 cycle for simple ops, W/4+1 for DADD, W+1 for MUL (W = 8 in byte mode, else WIDTH).
// Backpressure: result held in DONE until out_ready; a new request can be taken in that same cycle.
module alu_seq_msp430 #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_msp430_if.slave io,
  output logic [3:0] flags,
  input  logic       sr_we,
  input  logic [3:0] sr_wdata,
  output logic       busy
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDC = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SUBC = 4'd3;
  localparam logic [3:0] OP_CMP  = 4'd4;
  localparam logic [3:0] OP_DADD = 4'd5;
  localparam logic [3:0] OP_BIT  = 4'd6;
  localparam logic [3:0] OP_BIC  = 4'd7;
  localparam logic [3:0] OP_BIS  = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_AND  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_DADD, S_MUL, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   result_q, result_hi_q, wa, wb;
  logic [2*WIDTH-1:0] mcand, prod, pnext;
  logic [CW-1:0]      cnt, dlast, mlast;
  logic [3:0]         flags_q, alu_flags;
  logic               we_q, wbw, dcarry, accept;

  // sign bit of a value at the effective width
  function automatic logic msb(input logic [WIDTH-1:0] x, input logic bm);
    return bm ? x[7] : x[WIDTH-1];
  endfunction

  assign accept       = io.in_valid && io.in_ready;
  assign io.in_ready  = (state == S_IDLE) || (state == S_DONE && io.out_ready);
  assign io.out_valid = (state == S_DONE);
  assign io.result    = result_q;
  assign io.result_hi = result_hi_q;
  assign io.out_we    = we_q;
  assign flags        = flags_q;
  assign busy         = (state == S_DADD) || (state == S_MUL);
  assign dlast        = wbw ? CW'(1) : CW'(WIDTH/4 - 1);
  assign mlast        = wbw ? CW'(7) : CW'(WIDTH - 1);

  // single-cycle ops: operands truncated to the effective width, subtraction as A + ~B + cin
  logic [WIDTH-1:0] mask, at, bt, bsel, alu_res;
  logic [WIDTH:0]   sum;
  logic             cin, alu_c, alu_v, alu_upd, alu_we;
  always_comb begin
    mask = io.bw ? WIDTH'(8'hFF) : '1;
    at   = io.a & mask;
    bt   = io.b & mask;
    bsel = (io.op inside {OP_SUB, OP_SUBC, OP_CMP}) ? (~io.b & mask) : bt;
    case (io.op)
      OP_ADDC, OP_SUBC: cin = flags_q[1];
      OP_SUB, OP_CMP:   cin = 1'b1;
      default:          cin = 1'b0;
    endcase
    sum     = {1'b0, at} + {1'b0, bsel} + (WIDTH+1)'(cin);
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_upd = 1'b1;
    alu_we  = 1'b1;
    case (io.op)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: begin
        alu_res = sum[WIDTH-1:0] & mask;
        alu_c   = io.bw ? sum[8] : sum[WIDTH];
        alu_v   = (msb(at, io.bw) == msb(bsel, io.bw)) && (msb(alu_res, io.bw) != msb(at, io.bw));
        alu_we  = (io.op != OP_CMP);
      end
      OP_AND, OP_BIT: begin
        alu_res = at & bt;
        alu_c   = |alu_res;
        alu_we  = (io.op != OP_BIT);
      end
      OP_XOR: begin
        alu_res = at ^ bt;
        alu_c   = |alu_res;
        alu_v   = msb(at, io.bw) & msb(bt, io.bw);
      end
      OP_BIC: begin
        alu_res = at & ~bt;
        alu_upd = 1'b0;
      end
      OP_BIS: begin
        alu_res = at | bt;
        alu_upd = 1'b0;
      end
      default: begin
        alu_upd = 1'b0;
        alu_we  = 1'b0;
      end
    endcase
    alu_flags = {msb(alu_res, io.bw), (alu_res == '0), alu_c, alu_v};
  end

  // one BCD digit per cycle from the low nibbles of the shifting operands; multiply partial sum
  logic [4:0]       dsum;
  logic [3:0]       ddig;
  logic             dcout;
  logic [WIDTH-1:0] dres;
  always_comb begin
    dsum = {1'b0, wa[3:0]} + {1'b0, wb[3:0]} + 5'(dcarry);
    if (dsum > 5'd9) begin
      ddig  = 4'(dsum + 5'd6);
      dcout = 1'b1;
    end else begin
      ddig  = dsum[3:0];
      dcout = 1'b0;
    end
    dres = result_q;
    for (int i = 0; i < WIDTH/4; i++)
      if (cnt == CW'(i)) dres[4*i +: 4] = ddig;
    pnext = prod + (wb[0] ? mcand : '0);
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next state: a new accept (IDLE, or DONE with out_ready) dispatches on the opcode
  always_comb begin
    state_nxt = state;
    case (state)
      S_DADD:  if (cnt == dlast) state_nxt = S_DONE;
      S_MUL:   if (cnt == mlast) state_nxt = S_DONE;
      S_DONE:  if (io.out_ready) state_nxt = S_IDLE;
      default: state_nxt = state;
    endcase
    if (accept)
      state_nxt = (io.op == OP_DADD) ? S_DADD : (io.op == OP_MUL) ? S_MUL : S_DONE;
  end

  // datapath and status register; an external SR write overrides any op-driven update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      result_hi_q <= '0;
      we_q        <= 1'b0;
      flags_q     <= '0;
      wa          <= '0;
      wb          <= '0;
      mcand       <= '0;
      prod        <= '0;
      cnt         <= '0;
      wbw         <= 1'b0;
      dcarry      <= 1'b0;
    end else begin
      if (accept) begin
        wbw <= io.bw;
        cnt <= '0;
        case (io.op)
          OP_DADD: begin
            wa          <= at;
            wb          <= bt;
            dcarry      <= flags_q[1];
            result_q    <= '0;
            result_hi_q <= '0;
            we_q        <= 1'b1;
          end
          OP_MUL: begin
            mcand       <= {{WIDTH{1'b0}}, at};
            wb          <= bt;
            prod        <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            we_q        <= 1'b1;
          end
          default: begin
            result_q    <= alu_res;
            result_hi_q <= '0;
            we_q        <= alu_we;
            if (alu_upd) flags_q <= alu_flags;
          end
        endcase
      end else if (state == S_DADD) begin
        result_q <= dres;
        wa       <= wa >> 4;
        wb       <= wb >> 4;
        dcarry   <= dcout;
        cnt      <= cnt + CW'(1);
        if (cnt == dlast) flags_q <= {msb(dres, wbw), (dres == '0), dcout, 1'b0};
      end else if (state == S_MUL) begin
        prod  <= pnext;
        mcand <= mcand << 1;
        wb    <= wb >> 1;
        cnt   <= cnt + CW'(1);
        if (cnt == mlast) begin
          result_q    <= wbw ? WIDTH'(pnext[7:0])  : pnext[WIDTH-1:0];
          result_hi_q <= wbw ? WIDTH'(pnext[15:8]) : pnext[2*WIDTH-1:WIDTH];
        end
      end
      if (sr_we) flags_q <= sr_wdata;
    end
  end
endmodule

// File: tb/tb_alu_seq_msp430.sv
// Self-checking bench for alu_seq_msp430 at WIDTH=16: directed table, corner sequences, random vs model.
// Latency: measured in clock edges from the accept edge to the first cycle out_valid is seen.
// Backpressure: out_ready held low in DONE for a few cycles in the corner and random phases.
module tb_alu_seq_msp430;
  logic       clk, rst_n, sr_we, busy;
  logic [3:0] sr_wdata, flags;
  int         total, bad;
  logic [3:0] msr;

  alu_seq_msp430_if #(.WIDTH(16)) bus ();

  alu_seq_msp430 #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .io(bus), .flags(flags),
    .sr_we(sr_we), .sr_wdata(sr_wdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op; logic bw; logic [15:0] a, b; logic [3:0] sr;
    logic [15:0] res, hi; logic we; logic [3:0] fl; int lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // reference: plain integer arithmetic on the truncated operands, flags from the ISA definitions
  function automatic void ref_op(input logic [3:0] o, input logic bwm, input logic [15:0] a, b,
                                 input logic [3:0] sr, output logic [15:0] r, h, output logic we,
                                 output logic [3:0] f, output int lat);
    int w, bor, ci;
    longint m, half, av, bv, sa, sb, s, rr, hh;
    logic c, v, upd;
    w = bwm ? 8 : 16;
    m = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    av = longint'(a) & m;
    bv = longint'(b) & m;
    sa = (av >= half) ? av - 2*half : av;
    sb = (bv >= half) ? bv - 2*half : bv;
    rr = 0; hh = 0; c = 1'b0; v = 1'b0; upd = 1'b1; we = 1'b1; lat = 1;
    case (o)
      4'd0, 4'd1: begin
        ci = (o == 4'd1) ? int'(sr[1]) : 0;
        s = av + bv + ci; rr = s & m; c = (s > m);
        s = sa + sb + ci; v = (s >= half) || (s < -half);
      end
      4'd2, 4'd3, 4'd4: begin
        bor = (o == 4'd3) ? 1 - int'(sr[1]) : 0;
        rr = (av - bv - bor) & m; c = (av >= bv + bor);
        s = sa - sb - bor; v = (s >= half) || (s < -half);
        we = (o != 4'd4);
      end
      4'd5: begin
        c = sr[1];
        for (int d = 0; d < w/4; d++) begin
          s = ((av >> (4*d)) & 15) + ((bv >> (4*d)) & 15) + longint'(c);
          if (s > 9) begin s = s + 6; c = 1'b1; end
          else c = 1'b0;
          rr = rr | ((s & 15) << (4*d));
        end
        lat = w/4 + 1;
      end
      4'd6, 4'd10: begin rr = av & bv; c = (rr != 0); we = (o == 4'd10); end
      4'd7: begin rr = av & ~bv & m; upd = 1'b0; end
      4'd8: begin rr = av | bv; upd = 1'b0; end
      4'd9: begin rr = av ^ bv; c = (rr != 0); v = (av >= half) && (bv >= half); end
      4'd11: begin s = av * bv; rr = s & m; hh = s >> w; upd = 1'b0; lat = w + 1; end
      default: begin rr = 0; upd = 1'b0; we = 1'b0; end
    endcase
    r = 16'(rr);
    h = 16'(hh);
    f = upd ? {(rr >= half), (rr == 0), c, v} : sr;
  endfunction

  task automatic set_sr(input logic [3:0] v);
    sr_we = 1'b1; sr_wdata = v;
    @(posedge clk); #1;
    sr_we = 1'b0;
    msr = v;
  endtask

  task automatic run_op(input logic [3:0] o, input logic bwm, input logic [15:0] av, bv, input int hold,
                        output logic [15:0] r, h, output logic we, output logic [3:0] f,
                        output int lat, output int bc);
    int n;
    bus.op = o; bus.bw = bwm; bus.a = av; bus.b = bv;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1; bc = 0;
    while (!bus.out_valid && lat < 60) begin
      if (busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
    repeat (hold) begin @(posedge clk); #1; end
    r = bus.result; h = bus.result_hi; we = bus.out_we; f = flags;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  vec_t vt[16];

  initial begin
    logic [15:0] r, h, er, eh;
    logic        we, ewe;
    logic [3:0]  f, ef;
    int          lat, elat, bc;

    total = 0; bad = 0; msr = 4'h0;
    vt[0]  = '{4'd0,  1'b0, 16'h7FFF, 16'h0001, 4'h0, 16'h8000, 16'h0000, 1'b1, 4'b1001, 1};
    vt[1]  = '{4'd0,  1'b1, 16'h12FF, 16'h0001, 4'h0, 16'h0000, 16'h0000, 1'b1, 4'b0110, 1};
    vt[2]  = '{4'd5,  1'b0, 16'h0199, 16'h0001, 4'h0, 16'h0200, 16'h0000, 1'b1, 4'b0000, 5};
    vt[3]  = '{4'd5,  1'b0, 16'h9999, 16'h0001, 4'h0, 16'h0000, 16'h0000, 1'b1, 4'b0110, 5};
    vt[4]  = '{4'd11, 1'b0, 16'h1234, 16'h0100, 4'hA, 16'h3400, 16'h0012, 1'b1, 4'b1010, 17};
    vt[5]  = '{4'd2,  1'b0, 16'h0010, 16'h0001, 4'h0, 16'h000F, 16'h0000, 1'b1, 4'b0010, 1};
    vt[6]  = '{4'd4,  1'b0, 16'h0005, 16'h0005, 4'h0, 16'h0000, 16'h0000, 1'b0, 4'b0110, 1};
    vt[7]  = '{4'd9,  1'b0, 16'h8000, 16'h8001, 4'h0, 16'h0001, 16'h0000, 1'b1, 4'b0011, 1};
    vt[8]  = '{4'd6,  1'b0, 16'h00F0, 16'h0F0F, 4'h0, 16'h0000, 16'h0000, 1'b0, 4'b0100, 1};
    vt[9]  = '{4'd7,  1'b0, 16'hFFFF, 16'h00FF, 4'h5, 16'hFF00, 16'h0000, 1'b1, 4'b0101, 1};
    vt[10] = '{4'd8,  1'b0, 16'h0F00, 16'h00F0, 4'h0, 16'h0FF0, 16'h0000, 1'b1, 4'b0000, 1};
    vt[11] = '{4'd13, 1'b0, 16'h1234, 16'h5678, 4'hF, 16'h0000, 16'h0000, 1'b0, 4'b1111, 1};
    vt[12] = '{4'd1,  1'b0, 16'h0001, 16'h0001, 4'h2, 16'h0003, 16'h0000, 1'b1, 4'b0000, 1};
    vt[13] = '{4'd3,  1'b1, 16'hAB10, 16'hCD01, 4'h0, 16'h000E, 16'h0000, 1'b1, 4'b0010, 1};
    vt[14] = '{4'd5,  1'b1, 16'h1245, 16'h3454, 4'h2, 16'h0000, 16'h0000, 1'b1, 4'b0110, 3};
    vt[15] = '{4'd11, 1'b1, 16'h12FF, 16'h34FF, 4'h0, 16'h0001, 16'h00FE, 1'b1, 4'b0000, 9};

    rst_n = 1'b0; sr_we = 1'b0; sr_wdata = 4'h0;
    bus.in_valid = 1'b0; bus.op = 4'h0; bus.bw = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
    #12;
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.result", 32'(bus.result), 32'd0);
    chk("rst.result_hi", 32'(bus.result_hi), 32'd0);
    chk("rst.flags", 32'(flags), 32'd0);
    chk("rst.out_we", 32'(bus.out_we), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);

    // directed table
    for (int i = 0; i < 16; i++) begin
      set_sr(vt[i].sr);
      run_op(vt[i].op, vt[i].bw, vt[i].a, vt[i].b, 0, r, h, we, f, lat, bc);
      chk($sformatf("vec%0d.result", i), 32'(r), 32'(vt[i].res));
      chk($sformatf("vec%0d.result_hi", i), 32'(h), 32'(vt[i].hi));
      chk($sformatf("vec%0d.out_we", i), 32'(we), 32'(vt[i].we));
      chk($sformatf("vec%0d.flags", i), 32'(f), 32'(vt[i].fl));
      chk($sformatf("vec%0d.latency", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("vec%0d.busy_cycles", i), 32'(bc), 32'((vt[i].lat > 1) ? vt[i].lat - 1 : 0));
    end

    // back-to-back CMP then SUBC: SUBC must see the C written by CMP
    set_sr(4'h0);
    bus.op = 4'd4; bus.bw = 1'b0; bus.a = 16'h0005; bus.b = 16'h0005;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("b2b.cmp_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b.cmp_we", 32'(bus.out_we), 32'd0);
    chk("b2b.cmp_flags", 32'(flags), 32'b0110);
    chk("b2b.in_ready", 32'(bus.in_ready), 32'd1);
    bus.op = 4'd3; bus.a = 16'h0010; bus.b = 16'h0001;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("b2b.subc_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b.subc_result", 32'(bus.result), 32'h000F);
    chk("b2b.subc_flags", 32'(flags), 32'b0010);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    msr = 4'b0010;

    // DONE held with out_ready low while another request waits
    set_sr(4'h0);
    bus.op = 4'd0; bus.bw = 1'b0; bus.a = 16'h7FFF; bus.b = 16'h0001; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.a = 16'h0001;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hold%0d.out_valid", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("hold%0d.result", k), 32'(bus.result), 32'h8000);
      chk($sformatf("hold%0d.flags", k), 32'(flags), 32'b1001);
      chk($sformatf("hold%0d.in_ready", k), 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("hold.released", 32'(bus.out_valid), 32'd0);
    msr = 4'b1001;

    // external SR write on the same edge as an op's flag update
    bus.op = 4'd0; bus.a = 16'hFFFF; bus.b = 16'h0001; bus.in_valid = 1'b1;
    sr_we = 1'b1; sr_wdata = 4'b1001;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; sr_we = 1'b0;
    chk("srwe.result", 32'(bus.result), 32'h0000);
    chk("srwe.flags", 32'(flags), 32'b1001);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    msr = 4'b1001;

    // asynchronous reset in the middle of a multiply
    set_sr(4'hF);
    bus.op = 4'd11; bus.a = 16'h1234; bus.b = 16'h0100; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("mrst.busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst.flags", 32'(flags), 32'd0);
    chk("mrst.busy", 32'(busy), 32'd0);
    chk("mrst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("mrst.result", 32'(bus.result), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    msr = 4'h0;
    run_op(4'd0, 1'b0, 16'h0001, 16'h0002, 0, r, h, we, f, lat, bc);
    chk("mrst.after_result", 32'(r), 32'h0003);
    chk("mrst.after_flags", 32'(f), 32'h0);

    // random ops against the reference model, with SR tracked across operations
    for (int i = 0; i < 150; i++) begin
      logic [3:0]  o;
      logic        bwm;
      logic [15:0] av, bv;
      o = 4'($urandom_range(0, 15));
      bwm = 1'($urandom_range(0, 1));
      av = 16'($urandom);
      bv = 16'($urandom);
      if ($urandom_range(0, 3) == 0) set_sr(4'($urandom));
      ref_op(o, bwm, av, bv, msr, er, eh, ewe, ef, elat);
      run_op(o, bwm, av, bv, int'($urandom_range(0, 2)), r, h, we, f, lat, bc);
      msr = ef;
      chk($sformatf("rnd%0d.op%0d.result", i, o), 32'(r), 32'(er));
      chk($sformatf("rnd%0d.op%0d.result_hi", i, o), 32'(h), 32'(eh));
      chk($sformatf("rnd%0d.op%0d.out_we", i, o), 32'(we), 32'(ewe));
      chk($sformatf("rnd%0d.op%0d.flags", i, o), 32'(f), 32'(ef));
      chk($sformatf("rnd%0d.op%0d.latency", i, o), 32'(lat), 32'(elat));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
